// File: rtl/birds_pkg.sv
// Shared types and constants for the bird object generators feeding the birds mux.
package birds_pkg;

  typedef enum logic [2:0] {
    ST_PARKED  = 3'd0,
    ST_FLYING  = 3'd1,
    ST_HIT     = 3'd2,
    ST_FALLING = 3'd3,
    ST_DEAD    = 3'd4
  } bird_state_t;

  typedef logic [7:0] rgb332_t;

  localparam int      SPRITE_SIZE     = 32;
  localparam rgb332_t TRANSPARENT_RGB = 8'hFF;

endpackage

// File: rtl/bird_sprite_if.sv
// Frame/pixel/control strobes into one bird generator and its pixel/debug outputs.
interface bird_sprite_if;
  import birds_pkg::*;

  // No valid/ready here: startOfFrame, launch and hit are single-cycle strobes
  // sampled on every clk edge; pixelX/pixelY are valid every cycle and the
  // pixel outputs answer them exactly one clk later.
  logic               startOfFrame;
  logic signed [10:0] pixelX;
  logic signed [10:0] pixelY;
  logic               launch;
  logic signed [7:0]  launchSpeedX;
  logic signed [7:0]  launchSpeedY;
  logic               hit;
  logic               birdDrawingRequest;
  rgb332_t            birdRGB;
  logic signed [10:0] topLeftX;
  logic signed [10:0] topLeftY;
  logic [2:0]         birdState;

  modport master (
    output startOfFrame, pixelX, pixelY, launch, launchSpeedX, launchSpeedY, hit,
    input  birdDrawingRequest, birdRGB, topLeftX, topLeftY, birdState
  );

  modport slave (
    input  startOfFrame, pixelX, pixelY, launch, launchSpeedX, launchSpeedY, hit,
    output birdDrawingRequest, birdRGB, topLeftX, topLeftY, birdState
  );

endinterface

// File: rtl/bird_bitmap.sv
// Two 32x32 RGB332 bird frames (wings up / wings down), synchronous 1-cycle read.
module bird_bitmap
  import birds_pkg::*;
(
  input  logic        clk,
  input  logic [10:0] address,
  output rgb332_t     data
);

  logic    frame_w;
  logic [4:0] row_w;
  logic [4:0] col_w;
  rgb332_t pix_w;

  always_comb begin
    frame_w = address[10];
    row_w   = address[9:5];
    col_w   = address[4:0];
    pix_w   = TRANSPARENT_RGB;
    // Wing sits above the body in frame 0 and below it in frame 1.
    if (col_w >= 5'd10 && col_w <= 5'd17) begin
      if (!frame_w && row_w >= 5'd2 && row_w <= 5'd7) pix_w = 8'hE0;
      if (frame_w && row_w >= 5'd24 && row_w <= 5'd29) pix_w = 8'hE0;
    end
    if (col_w >= 5'd4 && col_w <= 5'd27 && row_w >= 5'd8 && row_w <= 5'd23) pix_w = 8'hFC;
    if (col_w == 5'd22 && row_w == 5'd12) pix_w = 8'h00;
  end

  always_ff @(posedge clk) begin
    data <= pix_w;
  end

endmodule

// File: rtl/bird_sprite.sv
// One bird: position/physics/life-cycle FSM plus a 1-clk pixel path into the bitmap ROM.
module bird_sprite
  import birds_pkg::*;
#(
  parameter int INIT_X         = 64,
  parameter int INIT_Y         = 300,
  parameter int GROUND_Y       = 448,
  parameter int SCREEN_W       = 640,
  parameter int GRAVITY        = 1,
  parameter int MAX_FALL       = 12,
  parameter int HIT_FRAMES     = 16,
  parameter int FLAP_FRAMES    = 6,
  parameter int RESPAWN_FRAMES = 60
) (
  input logic          clk,
  input logic          reset,
  bird_sprite_if.slave bus
);

  localparam int FW = $clog2(HIT_FRAMES + 1);
  localparam int RW = $clog2(RESPAWN_FRAMES);
  localparam int AW = $clog2(FLAP_FRAMES);

  localparam logic signed [11:0] FLOOR_Y   = 12'(GROUND_Y - SPRITE_SIZE);
  localparam logic signed [11:0] RIGHT_X   = 12'(SCREEN_W);
  localparam logic signed [11:0] LEFT_X    = 12'(-SPRITE_SIZE);
  localparam logic signed [11:0] SPRITE_S  = 12'(SPRITE_SIZE);
  localparam logic signed [8:0]  GRAV_S    = 9'(GRAVITY);
  localparam logic signed [8:0]  MAX_S     = 9'(MAX_FALL);
  localparam logic [AW-1:0]      FLAP_LAST = AW'(FLAP_FRAMES - 1);
  localparam logic [RW-1:0]      RESP_LAST = RW'(RESPAWN_FRAMES - 1);

  bird_state_t        state_q, state_d;
  logic signed [10:0] x_q, x_d, y_q, y_d;
  logic signed [7:0]  sx_q, sx_d, sy_q, sy_d;
  logic [FW-1:0]      flash_q, flash_d;
  logic [RW-1:0]      resp_q, resp_d;
  logic [AW-1:0]      flap_q, flap_d;
  logic               frame_q, frame_d;
  logic               inside_q, vis_q;

  logic signed [11:0] nx_w, ny_w, off_x_w, off_y_w;
  logic signed [8:0]  sy_inc_w;
  logic signed [7:0]  sy_sat_w;
  logic               ground_w, off_screen_w, inside_w, visible_w;
  logic [10:0]        addr_w;
  rgb332_t            rom_data;

  // Candidate motion for this frame, widened so the edge tests cannot wrap.
  always_comb begin
    nx_w         = $signed({x_q[10], x_q}) + $signed({{4{sx_q[7]}}, sx_q});
    ny_w         = $signed({y_q[10], y_q}) + $signed({{4{sy_q[7]}}, sy_q});
    sy_inc_w     = $signed({sy_q[7], sy_q}) + GRAV_S;
    sy_sat_w     = (sy_inc_w > MAX_S) ? MAX_S[7:0] : sy_inc_w[7:0];
    ground_w     = ny_w >= FLOOR_Y;
    off_screen_w = (nx_w >= RIGHT_X) || (nx_w < LEFT_X);
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    sx_d    = sx_q;
    sy_d    = sy_q;
    flash_d = flash_q;
    resp_d  = resp_q;
    flap_d  = flap_q;
    frame_d = frame_q;
    case (state_q)
      ST_PARKED: begin
        if (bus.launch) begin
          sx_d    = bus.launchSpeedX;
          sy_d    = bus.launchSpeedY;
          state_d = ST_FLYING;
        end
      end
      ST_FLYING: begin
        if (bus.hit) begin
          state_d = ST_HIT;
          sx_d    = '0;
          sy_d    = '0;
          flash_d = FW'(HIT_FRAMES);
          flap_d  = '0;
          frame_d = 1'b0;
        end else if (bus.startOfFrame) begin
          x_d  = nx_w[10:0];
          y_d  = ny_w[10:0];
          sy_d = sy_sat_w;
          if (flap_q == FLAP_LAST) begin
            flap_d  = '0;
            frame_d = ~frame_q;
          end else begin
            flap_d = flap_q + 1'b1;
          end
          if (ground_w || off_screen_w) begin
            state_d = ST_DEAD;
            flap_d  = '0;
            frame_d = 1'b0;
          end
          if (ground_w) y_d = FLOOR_Y[10:0];
        end
      end
      ST_HIT: begin
        if (bus.startOfFrame) begin
          flash_d = flash_q - 1'b1;
          if (flash_q == FW'(1)) state_d = ST_FALLING;
        end
      end
      ST_FALLING: begin
        if (bus.startOfFrame) begin
          y_d  = ny_w[10:0];
          sy_d = sy_sat_w;
          if (ground_w) begin
            y_d     = FLOOR_Y[10:0];
            state_d = ST_DEAD;
          end
        end
      end
      ST_DEAD: begin
        if (bus.startOfFrame) begin
          if (resp_q == RESP_LAST) begin
            state_d = ST_PARKED;
            x_d     = 11'(INIT_X);
            y_d     = 11'(INIT_Y);
            sx_d    = '0;
            sy_d    = '0;
            resp_d  = '0;
          end else begin
            resp_d = resp_q + 1'b1;
          end
        end
      end
      default: state_d = ST_PARKED;
    endcase
  end

  // Pixel path: offsets against the current position feed the ROM address.
  always_comb begin
    off_x_w   = $signed({bus.pixelX[10], bus.pixelX}) - $signed({x_q[10], x_q});
    off_y_w   = $signed({bus.pixelY[10], bus.pixelY}) - $signed({y_q[10], y_q});
    inside_w  = (off_x_w >= 12'sd0) && (off_x_w < SPRITE_S) &&
                (off_y_w >= 12'sd0) && (off_y_w < SPRITE_S);
    addr_w    = {frame_q, off_y_w[4:0], off_x_w[4:0]};
    visible_w = 1'b1;
    case (state_q)
      ST_HIT:  visible_w = flash_q[1];
      ST_DEAD: visible_w = 1'b0;
      default: visible_w = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_PARKED;
      x_q      <= 11'(INIT_X);
      y_q      <= 11'(INIT_Y);
      sx_q     <= '0;
      sy_q     <= '0;
      flash_q  <= '0;
      resp_q   <= '0;
      flap_q   <= '0;
      frame_q  <= 1'b0;
      inside_q <= 1'b0;
      vis_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      sx_q     <= sx_d;
      sy_q     <= sy_d;
      flash_q  <= flash_d;
      resp_q   <= resp_d;
      flap_q   <= flap_d;
      frame_q  <= frame_d;
      inside_q <= inside_w;
      vis_q    <= visible_w;
    end
  end

  bird_bitmap u_bitmap (
    .clk     (clk),
    .address (addr_w),
    .data    (rom_data)
  );

  assign bus.birdDrawingRequest = inside_q & vis_q & (rom_data != TRANSPARENT_RGB);
  assign bus.birdRGB            = bus.birdDrawingRequest ? rom_data : TRANSPARENT_RGB;
  assign bus.topLeftX           = x_q;
  assign bus.topLeftY           = y_q;
  assign bus.birdState          = state_q;

endmodule

// File: tb/tb_bird_sprite.sv
// Bench for bird_sprite: directed scenarios plus random flights against a frame-level model.
module tb_bird_sprite;

  localparam int S_PARKED = 0, S_FLYING = 1, S_HIT = 2, S_FALLING = 3, S_DEAD = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  bird_sprite_if bus ();

  bird_sprite dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model state, plain integers.
  int m_state, m_x, m_y, m_sx, m_sy, m_flash, m_resp, m_flap, m_frame;
  logic [7:0] bmp [0:1][0:31][0:31];
  logic [8:0] exp_q [$];

  task automatic paint(input int f, input int x0, input int x1, input int y0, input int y1,
                       input logic [7:0] c);
    for (int y = y0; y <= y1; y++)
      for (int x = x0; x <= x1; x++) bmp[f][y][x] = c;
  endtask

  task automatic build_bitmap();
    for (int f = 0; f < 2; f++) begin
      paint(f, 0, 31, 0, 31, 8'hFF);
      paint(f, 4, 27, 8, 23, 8'hFC);
      bmp[f][12][22] = 8'h00;
    end
    paint(0, 10, 17, 2, 7, 8'hE0);
    paint(1, 10, 17, 24, 29, 8'hE0);
  endtask

  task automatic m_reset();
    m_state = S_PARKED; m_x = 64; m_y = 300; m_sx = 0; m_sy = 0;
    m_flash = 0; m_resp = 0; m_flap = 0; m_frame = 0;
  endtask

  task automatic m_go_dead();
    m_state = S_DEAD; m_resp = 0; m_flap = 0; m_frame = 0;
  endtask

  task automatic m_update(input bit sof, input bit h, input bit l, input int lsx, input int lsy);
    case (m_state)
      S_PARKED: if (l) begin m_sx = lsx; m_sy = lsy; m_state = S_FLYING; end
      S_FLYING: begin
        if (h) begin
          m_state = S_HIT; m_sx = 0; m_sy = 0; m_flash = 16; m_flap = 0; m_frame = 0;
        end else if (sof) begin
          m_x += m_sx;
          m_y += m_sy;
          m_sy = (m_sy + 1 > 12) ? 12 : m_sy + 1;
          m_flap++;
          if (m_flap == 6) begin m_flap = 0; m_frame = 1 - m_frame; end
          if (m_y + 32 >= 448) begin m_y = 416; m_go_dead(); end
          else if (m_x >= 640 || m_x < -32) m_go_dead();
        end
      end
      S_HIT: if (sof) begin m_flash--; if (m_flash == 0) m_state = S_FALLING; end
      S_FALLING: if (sof) begin
        m_y += m_sy;
        m_sy = (m_sy + 1 > 12) ? 12 : m_sy + 1;
        if (m_y + 32 >= 448) begin m_y = 416; m_go_dead(); end
      end
      S_DEAD: if (sof) begin m_resp++; if (m_resp == 60) m_reset(); end
      default: ;
    endcase
  endtask

  function automatic logic [24:0] exp_pos();
    return {3'(m_state), 11'(m_x), 11'(m_y)};
  endfunction

  function automatic logic [24:0] obs_pos();
    return {bus.birdState, bus.topLeftX, bus.topLeftY};
  endfunction

  function automatic logic [8:0] exp_pix(input int px, input int py);
    int ox, oy;
    bit vis;
    ox  = px - m_x;
    oy  = py - m_y;
    vis = (m_state == S_PARKED) || (m_state == S_FLYING) || (m_state == S_FALLING) ||
          (m_state == S_HIT && (m_flash & 2) != 0);
    if (vis && ox >= 0 && ox < 32 && oy >= 0 && oy < 32 && bmp[m_frame][oy][ox] != 8'hFF)
      return {1'b1, bmp[m_frame][oy][ox]};
    return {1'b0, 8'hFF};
  endfunction

  // ---- driver tasks ----
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit sof, input bit h, input bit l, input int lsx, input int lsy);
    bus.startOfFrame = sof;
    bus.hit          = h;
    bus.launch       = l;
    bus.launchSpeedX = 8'(lsx);
    bus.launchSpeedY = 8'(lsy);
    step();
    bus.startOfFrame = 1'b0;
    bus.hit          = 1'b0;
    bus.launch       = 1'b0;
    m_update(sof, h, l, lsx, lsy);
  endtask

  task automatic frame();
    drive(1'b1, 1'b0, 1'b0, 0, 0);
  endtask

  task automatic probe(input int px, input int py, output logic [8:0] obs);
    bus.pixelX = 11'(px);
    bus.pixelY = 11'(py);
    step();
    obs = {bus.birdDrawingRequest, bus.birdRGB};
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
    m_reset();
  endtask

  // ---- tests ----
  task automatic test_reset();
    logic [8:0] obs;
    do_reset();
    n_checks++;
    if (obs_pos() !== {3'd0, 11'd64, 11'd300}) begin
      n_fail++; $display("FAIL reset_pos: got %h expected %h", obs_pos(), {3'd0, 11'd64, 11'd300});
    end
    n_checks++;
    if ({bus.birdDrawingRequest, bus.birdRGB} !== 9'h0FF) begin
      n_fail++; $display("FAIL reset_pix: got %h expected 0ff", {bus.birdDrawingRequest, bus.birdRGB});
    end
    probe(64, 300, obs);
    n_checks++;
    if (obs !== {1'b0, bmp[0][0][0]}) begin
      n_fail++; $display("FAIL pix_origin: got %h expected %h", obs, {1'b0, bmp[0][0][0]});
    end
    probe(63, 300, obs);
    n_checks++;
    if (obs !== 9'h0FF) begin n_fail++; $display("FAIL pix_left_edge: got %h expected 0ff", obs); end
    probe(74, 312, obs);
    n_checks++;
    if (obs !== 9'h1FC) begin n_fail++; $display("FAIL pix_body: got %h expected 1fc", obs); end
    probe(86, 312, obs);
    n_checks++;
    if (obs !== 9'h100) begin n_fail++; $display("FAIL pix_eye: got %h expected 100", obs); end
  endtask

  task automatic test_launch();
    do_reset();
    drive(1'b0, 1'b0, 1'b1, 4, -10);
    n_checks++;
    if (obs_pos() !== {3'd1, 11'd64, 11'd300}) begin
      n_fail++; $display("FAIL launch_state: got %h expected %h", obs_pos(), {3'd1, 11'd64, 11'd300});
    end
    frame();
    n_checks++;
    if (obs_pos() !== {3'd1, 11'd68, 11'd290}) begin
      n_fail++; $display("FAIL launch_f1: got %h expected %h", obs_pos(), {3'd1, 11'd68, 11'd290});
    end
    frame();
    n_checks++;
    if (obs_pos() !== {3'd1, 11'd72, 11'd281}) begin
      n_fail++; $display("FAIL launch_f2: got %h expected %h", obs_pos(), {3'd1, 11'd72, 11'd281});
    end
    frame();
    n_checks++;
    if (obs_pos() !== {3'd1, 11'd76, 11'd273}) begin
      n_fail++; $display("FAIL launch_f3: got %h expected %h", obs_pos(), {3'd1, 11'd76, 11'd273});
    end
  endtask

  task automatic test_ignored_pulses();
    do_reset();
    drive(1'b0, 1'b1, 1'b0, 0, 0);
    n_checks++;
    if (obs_pos() !== exp_pos() || bus.birdState !== 3'd0) begin
      n_fail++; $display("FAIL hit_in_parked: got %h expected %h", obs_pos(), exp_pos());
    end
    drive(1'b0, 1'b0, 1'b1, 4, -10);
    frame();
    drive(1'b0, 1'b0, 1'b1, 50, 50);
    frame();
    frame();
    n_checks++;
    if (obs_pos() !== exp_pos()) begin
      n_fail++; $display("FAIL launch_in_flying: got %h expected %h", obs_pos(), exp_pos());
    end
  endtask

  task automatic test_flap();
    logic [8:0] obs;
    logic [8:0] exp;
    do_reset();
    drive(1'b0, 1'b0, 1'b1, 4, -10);
    for (int i = 1; i <= 12; i++) begin
      frame();
      exp = exp_pix(m_x + 12, m_y + 4);
      probe(m_x + 12, m_y + 4, obs);
      n_checks++;
      if (obs !== exp) begin
        n_fail++; $display("FAIL flap_frame%0d: got %h expected %h", i, obs, exp);
      end
    end
    // Wing pixel is opaque only in frame 0: frames 6..11 show frame 1.
    n_checks++;
    if (m_frame != 0 || obs !== 9'h1E0) begin
      n_fail++; $display("FAIL flap_wrap12: got %h expected 1e0", obs);
    end
  endtask

  task automatic test_ground();
    logic [8:0] obs;
    do_reset();
    drive(1'b0, 1'b0, 1'b1, 0, 0);
    for (int i = 0; i < 40 && m_state != S_DEAD; i++) begin
      frame();
      n_checks++;
      if (obs_pos() !== exp_pos()) begin
        n_fail++; $display("FAIL ground_fall%0d: got %h expected %h", i, obs_pos(), exp_pos());
      end
    end
    n_checks++;
    if (obs_pos() !== {3'd4, 11'd64, 11'd416}) begin
      n_fail++; $display("FAIL ground_clamp: got %h expected %h", obs_pos(), {3'd4, 11'd64, 11'd416});
    end
    probe(74, 428, obs);
    n_checks++;
    if (obs !== 9'h0FF) begin n_fail++; $display("FAIL dead_invisible: got %h expected 0ff", obs); end
    for (int i = 1; i <= 60; i++) begin
      frame();
      if (i == 59) begin
        n_checks++;
        if (bus.birdState !== 3'd4) begin
          n_fail++; $display("FAIL dead_59: got %0d expected 4", bus.birdState);
        end
      end
    end
    n_checks++;
    if (obs_pos() !== {3'd0, 11'd64, 11'd300}) begin
      n_fail++; $display("FAIL respawn: got %h expected %h", obs_pos(), {3'd0, 11'd64, 11'd300});
    end
  endtask

  task automatic test_hit_and_reset();
    logic [8:0] obs;
    logic [8:0] exp;
    logic [24:0] held;
    logic [10:0] hx;
    do_reset();
    drive(1'b0, 1'b0, 1'b1, 3, -5);
    frame();
    frame();
    held = obs_pos();
    hx   = bus.topLeftX;
    drive(1'b1, 1'b1, 1'b0, 0, 0);
    n_checks++;
    if (obs_pos() !== {3'd2, held[21:0]}) begin
      n_fail++; $display("FAIL hit_with_sof: got %h expected %h", obs_pos(), {3'd2, held[21:0]});
    end
    for (int i = 1; i <= 16; i++) begin
      frame();
      exp = exp_pix(m_x + 10, m_y + 12);
      probe(m_x + 10, m_y + 12, obs);
      n_checks++;
      if (obs !== exp || obs_pos() !== exp_pos()) begin
        n_fail++; $display("FAIL hit_flash%0d: got %h/%h expected %h/%h", i, obs, obs_pos(), exp, exp_pos());
      end
    end
    n_checks++;
    if (bus.birdState !== 3'd3 || bus.topLeftX !== hx) begin
      n_fail++; $display("FAIL hit_to_falling: got %0d x=%0d expected 3 x=%0d", bus.birdState, bus.topLeftX, hx);
    end
    frame();
    frame();
    n_checks++;
    if (obs_pos() !== exp_pos() || bus.topLeftX !== hx) begin
      n_fail++; $display("FAIL falling_motion: got %h expected %h", obs_pos(), exp_pos());
    end
    bus.pixelX = 11'(m_x + 10);
    bus.pixelY = 11'(m_y + 12);
    reset = 1'b1;
    step();
    reset = 1'b0;
    m_reset();
    n_checks++;
    if ({obs_pos(), bus.birdDrawingRequest} !== {3'd0, 11'd64, 11'd300, 1'b0}) begin
      n_fail++; $display("FAIL reset_in_falling: got %h/%b expected %h/0", obs_pos(), bus.birdDrawingRequest,
                         {3'd0, 11'd64, 11'd300});
    end
  endtask

  task automatic test_random();
    logic [8:0] obs;
    logic [8:0] exp;
    for (int r = 0; r < 8; r++) begin
      do_reset();
      drive(1'b0, 1'b0, 1'b1, int'($urandom_range(16)) - 8, int'($urandom_range(25)) - 20);
      for (int f = 0; f < 100; f++) begin
        drive(1'b1, ($urandom_range(39) == 0), 1'b0, 0, 0);
        n_checks++;
        if (obs_pos() !== exp_pos()) begin
          n_fail++; $display("FAIL rand_pos r%0d f%0d: got %h expected %h", r, f, obs_pos(), exp_pos());
        end
        for (int p = 0; p < 2; p++) begin
          int px, py;
          px = m_x + int'($urandom_range(39)) - 4;
          py = m_y + int'($urandom_range(39)) - 4;
          exp_q.push_back(exp_pix(px, py));
          probe(px, py, obs);
          exp = exp_q.pop_front();
          n_checks++;
          if (obs !== exp) begin
            n_fail++; $display("FAIL rand_pix r%0d f%0d (%0d,%0d): got %h expected %h", r, f, px, py, obs, exp);
          end
        end
      end
    end
  endtask

  initial begin
    bus.startOfFrame = 1'b0;
    bus.hit          = 1'b0;
    bus.launch       = 1'b0;
    bus.launchSpeedX = '0;
    bus.launchSpeedY = '0;
    bus.pixelX       = '0;
    bus.pixelY       = '0;
    build_bitmap();
    m_reset();
    step();
    test_reset();
    test_launch();
    test_ignored_pulses();
    test_flap();
    test_ground();
    test_hit_and_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
